// File: rtl/rrf_alloc_if.sv
// Dispatch-side handshake between the DP stage and the RRF allocation scheduler.
//
// Handshake: dp_valid_i (with dp_req_num_i) is the request; alloc_grant_o is
// the combinational ready. A bundle transfers in the cycle where dp_valid_i
// and alloc_grant_o are both high, and it takes dst_tag0_o/dst_tag1_o from
// that same cycle. While stall_dp_o is high the dispatcher must hold the
// bundle unchanged and re-present it on the next cycle.
interface rrf_alloc_if #(
  parameter int RRF_SEL = 6
);
  logic               dp_valid_i;
  logic [1:0]         dp_req_num_i;
  logic               alloc_grant_o;
  logic [RRF_SEL-1:0] dst_tag0_o;
  logic [RRF_SEL-1:0] dst_tag1_o;
  logic               stall_dp_o;

  // Dispatch stage drives the request and consumes the grant and tags
  modport master (
    output dp_valid_i, dp_req_num_i,
    input  alloc_grant_o, dst_tag0_o, dst_tag1_o, stall_dp_o
  );

  // Scheduler consumes the request and drives the grant and tags
  modport slave (
    input  dp_valid_i, dp_req_num_i,
    output alloc_grant_o, dst_tag0_o, dst_tag1_o, stall_dp_o
  );
endinterface

// File: rtl/rrf_alloc_scheduler.sv
// Single owner of the rename register file pointers: grants 0-2 destination
// entries per cycle, tracks allocation/commit pointers and the free count,
// raises the dispatch stall and sequences misprediction recovery.
module rrf_alloc_scheduler #(
  parameter int RRF_NUM     = 64,
  parameter int RRF_SEL     = 6,
  parameter int RECOVER_CYC = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  rrf_alloc_if.slave         dp_if,
  input  logic [1:0]         com_inst_num_i,
  input  logic               flush_i,
  output logic [RRF_SEL-1:0] rrfptr_o,
  output logic [RRF_SEL-1:0] comptr_o,
  output logic [RRF_SEL:0]   freenum_o,
  output logic               nextrrfcyc_o,
  output logic               busy_o,
  output logic               err_o,
  output logic               state_dbg_o
);

  localparam int CNT_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [RRF_SEL:0]   C_NUM   = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [RRF_SEL+1:0] C_NUM_W = (RRF_SEL+2)'(RRF_NUM);

  typedef enum logic {
    S_RUN     = 1'b0,
    S_RECOVER = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;

  logic [RRF_SEL-1:0] r_rrfptr;
  logic [RRF_SEL-1:0] r_comptr;
  logic [RRF_SEL:0]   r_freenum;
  logic               r_nextrrfcyc;
  logic               r_err;

  logic               w_busy;
  logic               w_grant;
  logic [1:0]         w_req;
  logic [1:0]         w_gcnt;
  logic [RRF_SEL+1:0] w_avail;
  logic               w_fits;
  logic [RRF_SEL:0]   w_used;
  logic               w_underflow;
  logic [RRF_SEL+1:0] w_free_raw;
  logic [RRF_SEL:0]   w_free_nxt;
  logic [RRF_SEL-1:0] w_rrf_adv;
  logic [RRF_SEL-1:0] w_com_adv;

  // Pointer + n modulo RRF_NUM; RRF_NUM need not be a power of two
  function automatic logic [RRF_SEL-1:0] f_mod_add(input logic [RRF_SEL-1:0] ptr,
                                                   input logic [1:0]         n);
    logic [RRF_SEL:0] s;
    s = {1'b0, ptr} + {{(RRF_SEL-1){1'b0}}, n};
    if (s >= C_NUM) s = s - C_NUM;
    return s[RRF_SEL-1:0];
  endfunction

  // Request sizing, commit crediting and pointer arithmetic
  always_comb begin
    w_req       = (dp_if.dp_req_num_i == 2'd3) ? 2'd2 : dp_if.dp_req_num_i;
    // Same-cycle commits are credited so a bundle can reuse freed entries
    w_avail     = {1'b0, r_freenum} + {{RRF_SEL{1'b0}}, com_inst_num_i};
    w_fits      = (w_avail >= {{RRF_SEL{1'b0}}, w_req});
    w_used      = C_NUM - r_freenum;
    w_underflow = ({{(RRF_SEL-1){1'b0}}, com_inst_num_i} > w_used);
    w_gcnt      = w_grant ? w_req : 2'd0;
    // Cannot go negative: a grant is only given when w_avail covers it
    w_free_raw  = w_avail - {{RRF_SEL{1'b0}}, w_gcnt};
    w_free_nxt  = (w_free_raw > C_NUM_W) ? C_NUM : w_free_raw[RRF_SEL:0];
    w_rrf_adv   = f_mod_add(r_rrfptr, w_gcnt);
    w_com_adv   = f_mod_add(r_comptr, com_inst_num_i);
  end

  // FSM state register plus the recovery cycle counter
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i)
        r_cnt <= CNT_W'(RECOVER_CYC - 1);
      else if (r_state == S_RECOVER && r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // FSM next state: any flush (re)enters RECOVER, counter expiry returns to RUN
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i)
      w_state_nxt = S_RECOVER;
    else if (r_state == S_RECOVER && r_cnt == '0)
      w_state_nxt = S_RUN;
  end

  // FSM outputs: grant only while running and not flushing
  always_comb begin
    w_busy  = (r_state == S_RECOVER);
    w_grant = dp_if.dp_valid_i & ~w_busy & ~flush_i & w_fits;
  end

  // Pointer, free count, wrap pulse and sticky error registers
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_rrfptr     <= '0;
      r_comptr     <= '0;
      r_freenum    <= C_NUM;
      r_nextrrfcyc <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Retirement always moves the commit pointer, even on underflow
      r_comptr <= w_com_adv;
      if (w_underflow) r_err <= 1'b1;
      if (flush_i || w_busy) begin
        // Squash everything younger than the commit point
        r_rrfptr     <= w_com_adv;
        r_freenum    <= C_NUM;
        r_nextrrfcyc <= 1'b0;
      end else begin
        r_rrfptr     <= w_rrf_adv;
        r_freenum    <= w_free_nxt;
        r_nextrrfcyc <= (w_rrf_adv < r_rrfptr);
      end
    end
  end

  assign dp_if.alloc_grant_o = w_grant;
  assign dp_if.dst_tag0_o    = r_rrfptr;
  assign dp_if.dst_tag1_o    = f_mod_add(r_rrfptr, 2'd1);
  assign dp_if.stall_dp_o    = dp_if.dp_valid_i & ~w_grant;

  assign rrfptr_o     = r_rrfptr;
  assign comptr_o     = r_comptr;
  assign freenum_o    = r_freenum;
  assign nextrrfcyc_o = r_nextrrfcyc;
  assign busy_o       = w_busy;
  assign err_o        = r_err;
  assign state_dbg_o  = r_state;

endmodule

// File: tb/tb_rrf_alloc_scheduler.sv
// Self-checking bench for rrf_alloc_scheduler: directed scenarios plus a
// randomized run against an integer/queue reference model.
module tb_rrf_alloc_scheduler;

  localparam int RRF_NUM     = 64;
  localparam int RRF_SEL     = 6;
  localparam int RECOVER_CYC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic [1:0]         com_inst_num_i;
  logic               flush_i;
  logic [RRF_SEL-1:0] rrfptr_o;
  logic [RRF_SEL-1:0] comptr_o;
  logic [RRF_SEL:0]   freenum_o;
  logic               nextrrfcyc_o;
  logic               busy_o;
  logic               err_o;
  logic               state_dbg_o;

  rrf_alloc_if #(.RRF_SEL(RRF_SEL)) dp_if ();

  rrf_alloc_scheduler #(
    .RRF_NUM(RRF_NUM), .RRF_SEL(RRF_SEL), .RECOVER_CYC(RECOVER_CYC)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .dp_if(dp_if.slave),
    .com_inst_num_i(com_inst_num_i), .flush_i(flush_i),
    .rrfptr_o(rrfptr_o), .comptr_o(comptr_o), .freenum_o(freenum_o),
    .nextrrfcyc_o(nextrrfcyc_o), .busy_o(busy_o), .err_o(err_o),
    .state_dbg_o(state_dbg_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Architectural view: pointers as integers mod RRF_NUM, free count, number
  // of recovery cycles still to be spent, and the in-flight tag queue.
  int m_rrf, m_com, m_free, m_busy_left;
  bit m_err, m_wrap;
  logic [RRF_SEL-1:0] exp_q[$];

  // current inputs and combinational expectations for this cycle
  bit cur_v, cur_f;
  int cur_req, cur_com;
  bit exp_grant, exp_stall;
  logic [RRF_SEL-1:0] exp_tag0, exp_tag1;

  task automatic model_reset();
    m_rrf = 0; m_com = 0; m_free = RRF_NUM; m_busy_left = 0;
    m_err = 0; m_wrap = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b0;
    dp_if.dp_valid_i = 1'b0; dp_if.dp_req_num_i = 2'd0;
    com_inst_num_i = 2'd0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 reset_i = 1'b1;
  endtask

  // Drive one cycle's inputs at the falling edge and form expectations
  task automatic set_in(input bit v, input int req, input int com, input bit f);
    int eff;
    @(negedge clk);
    dp_if.dp_valid_i = v; dp_if.dp_req_num_i = 2'(req);
    com_inst_num_i = 2'(com); flush_i = f;
    #1;
    cur_v = v; cur_req = req; cur_com = com; cur_f = f;
    eff = (req > 2) ? 2 : req;
    exp_grant = v && (m_busy_left == 0) && !f && (m_free + com >= eff);
    exp_stall = v && !exp_grant;
    exp_tag0  = RRF_SEL'(m_rrf);
    exp_tag1  = RRF_SEL'((m_rrf + 1) % RRF_NUM);
  endtask

  // Advance the model by one edge, then let the DUT take the edge
  task automatic tick();
    int eff, g, new_com;
    eff = (cur_req > 2) ? 2 : cur_req;
    g = exp_grant ? eff : 0;
    new_com = (m_com + cur_com) % RRF_NUM;
    if (cur_com > RRF_NUM - m_free) m_err = 1;
    for (int k = 0; k < cur_com; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (cur_f || m_busy_left > 0) begin
      m_rrf = new_com; m_free = RRF_NUM; m_wrap = 0;
      exp_q.delete();
    end else begin
      for (int k = 0; k < g; k++) exp_q.push_back(RRF_SEL'((m_rrf + k) % RRF_NUM));
      m_wrap = (m_rrf + g >= RRF_NUM);
      m_rrf  = (m_rrf + g) % RRF_NUM;
      m_free = m_free + cur_com - g;
      if (m_free > RRF_NUM) m_free = RRF_NUM;
    end
    m_com = new_com;
    if (cur_f) m_busy_left = RECOVER_CYC;
    else if (m_busy_left > 0) m_busy_left--;
    @(posedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    set_in(0, 0, 0, 0);
    n_checks += 6;
    if (rrfptr_o !== '0) begin n_errors++; $display("FAIL reset_rrfptr got=%0d exp=0", rrfptr_o); end
    if (comptr_o !== '0) begin n_errors++; $display("FAIL reset_comptr got=%0d exp=0", comptr_o); end
    if (freenum_o !== 7'd64) begin n_errors++; $display("FAIL reset_freenum got=%0d exp=64", freenum_o); end
    if (nextrrfcyc_o !== 1'b0) begin n_errors++; $display("FAIL reset_nextrrfcyc got=%0b exp=0", nextrrfcyc_o); end
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    if (err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%0b exp=0", err_o); end
    tick();
  endtask

  task automatic test_fill();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      set_in(1, 2, 0, 0);
      pulses += int'(nextrrfcyc_o);
      n_checks += 3;
      if (dp_if.alloc_grant_o !== 1'b1) begin n_errors++; $display("FAIL fill_grant i=%0d got=%0b exp=1", i, dp_if.alloc_grant_o); end
      if (dp_if.dst_tag0_o !== RRF_SEL'(2*i)) begin n_errors++; $display("FAIL fill_tag0 i=%0d got=%0d exp=%0d", i, dp_if.dst_tag0_o, 2*i); end
      if (dp_if.dst_tag1_o !== RRF_SEL'(2*i+1)) begin n_errors++; $display("FAIL fill_tag1 i=%0d got=%0d exp=%0d", i, dp_if.dst_tag1_o, 2*i+1); end
      tick();
    end
    set_in(1, 2, 0, 0);
    pulses += int'(nextrrfcyc_o);
    n_checks += 4;
    if (dp_if.stall_dp_o !== 1'b1) begin n_errors++; $display("FAIL full_stall got=%0b exp=1", dp_if.stall_dp_o); end
    if (rrfptr_o !== '0) begin n_errors++; $display("FAIL full_rrfptr got=%0d exp=0", rrfptr_o); end
    if (freenum_o !== '0) begin n_errors++; $display("FAIL full_freenum got=%0d exp=0", freenum_o); end
    if (pulses != 1) begin n_errors++; $display("FAIL full_wrap_pulses got=%0d exp=1", pulses); end
    tick();
  endtask

  // continues from the full state left by test_fill
  task automatic test_same_cycle_credit();
    set_in(1, 2, 2, 0);
    n_checks += 2;
    if (dp_if.alloc_grant_o !== 1'b1) begin n_errors++; $display("FAIL credit_grant got=%0b exp=1", dp_if.alloc_grant_o); end
    if (dp_if.stall_dp_o !== 1'b0) begin n_errors++; $display("FAIL credit_stall got=%0b exp=0", dp_if.stall_dp_o); end
    tick();
    set_in(0, 0, 0, 0);
    n_checks += 3;
    if (freenum_o !== '0) begin n_errors++; $display("FAIL credit_freenum got=%0d exp=0", freenum_o); end
    if (rrfptr_o !== 6'd2) begin n_errors++; $display("FAIL credit_rrfptr got=%0d exp=2", rrfptr_o); end
    if (comptr_o !== 6'd2) begin n_errors++; $display("FAIL credit_comptr got=%0d exp=2", comptr_o); end
    tick();
  endtask

  task automatic test_partial();
    set_in(0, 0, 1, 0);
    tick();
    set_in(1, 2, 0, 0);
    n_checks += 2;
    if (freenum_o !== 7'd1) begin n_errors++; $display("FAIL partial_freenum got=%0d exp=1", freenum_o); end
    if (dp_if.stall_dp_o !== 1'b1) begin n_errors++; $display("FAIL partial_stall got=%0b exp=1", dp_if.stall_dp_o); end
    tick();
    set_in(1, 2, 1, 0);
    n_checks += 1;
    if (dp_if.alloc_grant_o !== 1'b1) begin n_errors++; $display("FAIL partial_grant got=%0b exp=1", dp_if.alloc_grant_o); end
    tick();
    set_in(0, 0, 0, 0);
    n_checks += 2;
    if (freenum_o !== '0) begin n_errors++; $display("FAIL partial_freenum_after got=%0d exp=0", freenum_o); end
    if (rrfptr_o !== 6'd4) begin n_errors++; $display("FAIL partial_rrfptr got=%0d exp=4", rrfptr_o); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 31; i++) begin set_in(1, 2, 0, 0); tick(); end
    set_in(1, 1, 0, 0); tick();
    set_in(1, 2, 1, 0);
    n_checks += 3;
    if (dp_if.alloc_grant_o !== 1'b1) begin n_errors++; $display("FAIL wrap_grant got=%0b exp=1", dp_if.alloc_grant_o); end
    if (dp_if.dst_tag0_o !== 6'd63) begin n_errors++; $display("FAIL wrap_tag0 got=%0d exp=63", dp_if.dst_tag0_o); end
    if (dp_if.dst_tag1_o !== 6'd0) begin n_errors++; $display("FAIL wrap_tag1 got=%0d exp=0", dp_if.dst_tag1_o); end
    tick();
    set_in(0, 0, 0, 0);
    n_checks += 2;
    if (rrfptr_o !== 6'd1) begin n_errors++; $display("FAIL wrap_rrfptr got=%0d exp=1", rrfptr_o); end
    if (nextrrfcyc_o !== 1'b1) begin n_errors++; $display("FAIL wrap_pulse got=%0b exp=1", nextrrfcyc_o); end
    tick();
    set_in(0, 0, 0, 0);
    n_checks += 1;
    if (nextrrfcyc_o !== 1'b0) begin n_errors++; $display("FAIL wrap_pulse_end got=%0b exp=0", nextrrfcyc_o); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 20; i++) begin set_in(1, 2, 0, 0); tick(); end
    for (int i = 0; i < 5; i++) begin set_in(0, 0, 2, 0); tick(); end
    set_in(1, 1, 1, 1);
    n_checks += 4;
    if (rrfptr_o !== 6'd40 || comptr_o !== 6'd10) begin n_errors++; $display("FAIL flush_setup got=%0d/%0d exp=40/10", rrfptr_o, comptr_o); end
    if (dp_if.alloc_grant_o !== 1'b0) begin n_errors++; $display("FAIL flush_grant got=%0b exp=0", dp_if.alloc_grant_o); end
    if (dp_if.stall_dp_o !== 1'b1) begin n_errors++; $display("FAIL flush_stall got=%0b exp=1", dp_if.stall_dp_o); end
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_busy_n got=%0b exp=0", busy_o); end
    tick();
    set_in(1, 1, 0, 0);
    n_checks += 5;
    if (rrfptr_o !== 6'd11) begin n_errors++; $display("FAIL flush_rrfptr got=%0d exp=11", rrfptr_o); end
    if (comptr_o !== 6'd11) begin n_errors++; $display("FAIL flush_comptr got=%0d exp=11", comptr_o); end
    if (freenum_o !== 7'd64) begin n_errors++; $display("FAIL flush_freenum got=%0d exp=64", freenum_o); end
    if (busy_o !== 1'b1) begin n_errors++; $display("FAIL flush_busy_n1 got=%0b exp=1", busy_o); end
    if (dp_if.alloc_grant_o !== 1'b0) begin n_errors++; $display("FAIL flush_grant_n1 got=%0b exp=0", dp_if.alloc_grant_o); end
    tick();
    set_in(1, 1, 0, 0);
    n_checks += 2;
    if (busy_o !== 1'b1) begin n_errors++; $display("FAIL flush_busy_n2 got=%0b exp=1", busy_o); end
    if (dp_if.alloc_grant_o !== 1'b0) begin n_errors++; $display("FAIL flush_grant_n2 got=%0b exp=0", dp_if.alloc_grant_o); end
    tick();
    set_in(1, 1, 0, 0);
    n_checks += 2;
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_busy_n3 got=%0b exp=0", busy_o); end
    if (dp_if.alloc_grant_o !== 1'b1) begin n_errors++; $display("FAIL flush_grant_n3 got=%0b exp=1", dp_if.alloc_grant_o); end
    tick();
    // reset taken while in RECOVER
    set_in(0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0);
    n_checks += 1;
    if (busy_o !== 1'b1) begin n_errors++; $display("FAIL recov_busy got=%0b exp=1", busy_o); end
    tick();
    do_reset();
    set_in(1, 2, 0, 0);
    n_checks += 4;
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL recov_reset_busy got=%0b exp=0", busy_o); end
    if (rrfptr_o !== '0 || comptr_o !== '0) begin n_errors++; $display("FAIL recov_reset_ptrs got=%0d/%0d exp=0/0", rrfptr_o, comptr_o); end
    if (freenum_o !== 7'd64) begin n_errors++; $display("FAIL recov_reset_freenum got=%0d exp=64", freenum_o); end
    if (dp_if.alloc_grant_o !== 1'b1) begin n_errors++; $display("FAIL recov_reset_grant got=%0b exp=1", dp_if.alloc_grant_o); end
    tick();
  endtask

  task automatic test_underflow();
    do_reset();
    set_in(0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0);
    n_checks += 3;
    if (err_o !== 1'b1) begin n_errors++; $display("FAIL uflow_err got=%0b exp=1", err_o); end
    if (freenum_o !== 7'd64) begin n_errors++; $display("FAIL uflow_freenum got=%0d exp=64", freenum_o); end
    if (comptr_o !== 6'd1) begin n_errors++; $display("FAIL uflow_comptr got=%0d exp=1", comptr_o); end
    tick();
    for (int i = 0; i < 3; i++) begin set_in(1, 1, 0, 0); tick(); end
    set_in(0, 0, 0, 0);
    n_checks += 1;
    if (err_o !== 1'b1) begin n_errors++; $display("FAIL uflow_sticky got=%0b exp=1", err_o); end
    tick();
    do_reset();
    set_in(0, 0, 0, 0);
    n_checks += 1;
    if (err_o !== 1'b0) begin n_errors++; $display("FAIL uflow_clear got=%0b exp=0", err_o); end
    tick();
  endtask

  task automatic test_random();
    int outstanding, c;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      outstanding = RRF_NUM - m_free;
      c = $urandom_range(0, (outstanding < 2) ? outstanding : 2);
      set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 3), c, ($urandom_range(0, 24) == 0));
      n_checks += 12;
      if (dp_if.alloc_grant_o !== exp_grant) begin n_errors++; $display("FAIL rnd_grant cyc=%0d got=%0b exp=%0b", cyc, dp_if.alloc_grant_o, exp_grant); end
      if (dp_if.stall_dp_o !== exp_stall) begin n_errors++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, dp_if.stall_dp_o, exp_stall); end
      if (dp_if.dst_tag0_o !== exp_tag0) begin n_errors++; $display("FAIL rnd_tag0 cyc=%0d got=%0d exp=%0d", cyc, dp_if.dst_tag0_o, exp_tag0); end
      if (dp_if.dst_tag1_o !== exp_tag1) begin n_errors++; $display("FAIL rnd_tag1 cyc=%0d got=%0d exp=%0d", cyc, dp_if.dst_tag1_o, exp_tag1); end
      if (rrfptr_o !== RRF_SEL'(m_rrf)) begin n_errors++; $display("FAIL rnd_rrfptr cyc=%0d got=%0d exp=%0d", cyc, rrfptr_o, m_rrf); end
      if (comptr_o !== RRF_SEL'(m_com)) begin n_errors++; $display("FAIL rnd_comptr cyc=%0d got=%0d exp=%0d", cyc, comptr_o, m_com); end
      if (freenum_o !== (RRF_SEL+1)'(m_free)) begin n_errors++; $display("FAIL rnd_freenum cyc=%0d got=%0d exp=%0d", cyc, freenum_o, m_free); end
      if (freenum_o !== (RRF_SEL+1)'(RRF_NUM - exp_q.size())) begin n_errors++; $display("FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", cyc, freenum_o, RRF_NUM - exp_q.size()); end
      if (exp_q.size() > 0 && comptr_o !== exp_q[0]) begin n_errors++; $display("FAIL rnd_oldest cyc=%0d got=%0d exp=%0d", cyc, comptr_o, exp_q[0]); end
      if (nextrrfcyc_o !== m_wrap) begin n_errors++; $display("FAIL rnd_wrap cyc=%0d got=%0b exp=%0b", cyc, nextrrfcyc_o, m_wrap); end
      if (busy_o !== (m_busy_left > 0)) begin n_errors++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy_o, (m_busy_left > 0)); end
      if (err_o !== m_err) begin n_errors++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err_o, m_err); end
      tick();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  // ---------------- sequence + final report ----------------
  initial begin
    reset_i = 1'b0;
    dp_if.dp_valid_i = 1'b0; dp_if.dp_req_num_i = 2'd0;
    com_inst_num_i = 2'd0; flush_i = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_same_cycle_credit();
    test_partial();
    test_wrap();
    test_flush();
    test_underflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rrf_alloc_scheduler.md
# rrf_alloc_scheduler

Allocation scheduler for the rename register file (RRF) in the DP stage. It grants 0–2 destination RRF entries per cycle to the dual-issue dispatch slots, and tracks the allocation pointer, the commit pointer and the free count. It generates the dispatch stall and sequences misprediction recovery through a small state machine. It replaces per-slot allocation logic with a single owner of the RRF pointers.

## Interface
Parameters:
- RRF_NUM, 64, number of RRF entries (any value ≥ 4, not required to be a power of two)
- RRF_SEL, 6, tag width, ceil(log2(RRF_NUM))
- RECOVER_CYC, 2, cycles spent in RECOVER after a flush (≥ 1)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  reset, synchronous, active-low
- dp_valid_i  in  1  dispatch bundle valid this cycle
- dp_req_num_i  in  2  destination entries requested by the bundle, 0–2; value 3 is illegal
- com_inst_num_i  in  2  entries retired by COM this cycle, 0–2
- flush_i  in  1  misprediction flush pulse
- alloc_grant_o  out  1  bundle accepted this cycle (combinational)
- dst_tag0_o  out  RRF_SEL  tag for slot 0, equals rrfptr_o
- dst_tag1_o  out  RRF_SEL  tag for slot 1, (rrfptr_o+1) mod RRF_NUM
- stall_dp_o  out  1  dispatch must hold, equals dp_valid_i & ~alloc_grant_o
- rrfptr_o  out  RRF_SEL  next tag to allocate (registered)
- comptr_o  out  RRF_SEL  oldest unretired tag (registered)
- freenum_o  out  RRF_SEL+1  free entry count (registered)
- nextrrfcyc_o  out  1  allocation pointer wrapped on the previous edge (registered, 1-cycle pulse)
- busy_o  out  1  state is RECOVER
- err_o  out  1  sticky commit-underflow flag

## Operation
- States: RUN, RECOVER. Reset enters RUN.
- Reset values: rrfptr_o=0, comptr_o=0, freenum_o=RRF_NUM, nextrrfcyc_o=0, err_o=0, recover counter=0, busy_o=0.
- Grant: alloc_grant_o = dp_valid_i & state==RUN & ~flush_i & (freenum_o + com_inst_num_i ≥ dp_req_num_i).
  - Commits in the same cycle are credited combinationally, so a bundle may use entries freed that cycle.
  - dp_valid_i with dp_req_num_i=0 is granted and consumes nothing.
- RUN update, per edge with no flush:
  - freenum_o += com_inst_num_i − (grant ? dp_req_num_i : 0)
  - rrfptr_o advances by the granted count, modulo RRF_NUM
  - comptr_o advances by com_inst_num_i, modulo RRF_NUM
- Modulo arithmetic: compute ptr+n in RRF_SEL+1 bits; subtract RRF_NUM when the result is ≥ RRF_NUM.
- nextrrfcyc_o: next value = 1 iff the rrfptr update wrapped (new value < old value). Otherwise 0, including under stall and recovery.
- Commit underflow: if com_inst_num_i > RRF_NUM − freenum_o, set err_o (cleared only by reset). freenum_o saturates at RRF_NUM. comptr_o still advances.
- Flush:
  - flush_i high in any state: no grant that cycle.
  - Next edge: comptr_o advances by com_inst_num_i, rrfptr_o loads the new comptr_o value, freenum_o=RRF_NUM.
  - Next edge also: state=RECOVER, counter=RECOVER_CYC−1.
- RECOVER:
  - alloc_grant_o=0. Commits still update comptr_o; rrfptr_o tracks comptr_o; freenum_o stays RRF_NUM.
  - Counter decrements each edge; at counter 0 the next edge returns to RUN.
  - A flush during RECOVER reloads the counter.
- Illegal dp_req_num_i=3 is treated as 2.

## Timing
- Grant, tags and stall are combinational from the inputs and registered state, in the same cycle.
- Registered outputs reflect an accepted bundle one cycle later.
- Flush at cycle N: busy_o high for cycles N+1 … N+RECOVER_CYC; first possible grant at cycle N+RECOVER_CYC+1.
- Reset asserted mid-operation, including during RECOVER: all state returns to reset values on that edge, and outputs are valid with reset values the following cycle.

## Test plan
- Reset, then 32 cycles of dp_req_num_i=2 with no commits → tags 0/1, 2/3, …, 62/63; freenum_o reaches 0; the 33rd request stalls (stall_dp_o=1, rrfptr_o=0, nextrrfcyc_o pulsed once).
- freenum_o=0, dp_req_num_i=2 with com_inst_num_i=2 in the same cycle → granted; freenum_o stays 0.
- freenum_o=1, request 2, commit 0 → stall. Next cycle commit 1 → granted; freenum_o=0.
- rrfptr_o=63, request 2 → tags 63/0; rrfptr_o=1 next cycle; nextrrfcyc_o=1 for exactly one cycle.
- comptr_o=10, rrfptr_o=40, flush_i with com_inst_num_i=1 → next cycle rrfptr_o=11, comptr_o=11, freenum_o=64, busy_o high for 2 cycles; grants blocked until cycle N+3.
- freenum_o=64, com_inst_num_i=1 → err_o=1 and stays set until reset_i=0; freenum_o stays 64.
